// File: rtl/jk_seq_checker.sv
// Receive-side checker for the 7-state JK counter code sequence.
// Locks onto the sequence, flywheels through mismatches and counts errors.
module jk_seq_checker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       code,
  input  logic             code_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [2:0]       pos,
  output logic [2:0]       expected,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       trk_reg, trk_next;
  logic             trk_ok_reg, trk_ok_next;
  logic [2:0]       good_reg, good_next;
  logic [2:0]       bad_reg, bad_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic             seq_err_reg, seq_err_next;
  logic             wrap_reg, wrap_next;

  // 011 is not part of the sequence; it maps to 000 only as a don't-care.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  next_code = 3'b001;
      3'b001:  next_code = 3'b010;
      3'b010:  next_code = 3'b100;
      3'b100:  next_code = 3'b101;
      3'b101:  next_code = 3'b110;
      3'b110:  next_code = 3'b111;
      default: next_code = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] pos_of(input logic [2:0] c);
    case (c)
      3'b001:  pos_of = 3'd1;
      3'b010:  pos_of = 3'd2;
      3'b100:  pos_of = 3'd3;
      3'b101:  pos_of = 3'd4;
      3'b110:  pos_of = 3'd5;
      3'b111:  pos_of = 3'd6;
      default: pos_of = 3'd0;
    endcase
  endfunction

  logic [2:0] trk_succ;
  logic       code_legal;
  logic       match;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  assign trk_succ   = next_code(trk_reg);
  assign code_legal = (code != 3'b011);
  assign match      = trk_ok_reg && (code == trk_succ);
  assign good_inc   = {1'b0, good_reg} + 4'd1;
  assign bad_inc    = {1'b0, bad_reg} + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= HUNT;
      trk_reg     <= 3'b000;
      trk_ok_reg  <= 1'b0;
      good_reg    <= 3'd0;
      bad_reg     <= 3'd0;
      err_reg     <= '0;
      seq_err_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      trk_reg     <= trk_next;
      trk_ok_reg  <= trk_ok_next;
      good_reg    <= good_next;
      bad_reg     <= bad_next;
      err_reg     <= err_next;
      seq_err_reg <= seq_err_next;
      wrap_reg    <= wrap_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    trk_next     = trk_reg;
    trk_ok_next  = trk_ok_reg;
    good_next    = good_reg;
    bad_next     = bad_reg;
    err_next     = err_reg;
    seq_err_next = 1'b0;
    wrap_next    = 1'b0;

    if (code_valid) begin
      case (state_reg)
        HUNT: begin
          if (match) begin
            trk_next = code;
            if (good_inc >= 4'(LOCK_CNT)) begin
              state_next = LOCKED;
              bad_next   = 3'd0;
              good_next  = 3'd0;
            end else begin
              good_next = good_inc[2:0];
            end
          end else begin
            good_next = 3'd0;
            if (code_legal) begin
              trk_next    = code;
              trk_ok_next = 1'b1;
            end else begin
              trk_ok_next = 1'b0;
            end
          end
        end
        LOCKED: begin
          if (match) begin
            trk_next  = code;
            bad_next  = 3'd0;
            wrap_next = (trk_reg == 3'b111);
          end else begin
            seq_err_next = 1'b1;
            if (err_reg != '1) err_next = err_reg + ERR_W'(1);
            // Flywheel: advance along the sequence, never adopt the bad code.
            trk_next = trk_succ;
            if (bad_inc >= 4'(UNLOCK_CNT)) begin
              state_next = HUNT;
              bad_next   = 3'd0;
              good_next  = 3'd0;
              if (code_legal) begin
                trk_next    = code;
                trk_ok_next = 1'b1;
              end else begin
                trk_ok_next = 1'b0;
              end
            end else begin
              bad_next = bad_inc[2:0];
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (clr_err) err_next = '0;
  end

  assign locked    = (state_reg == LOCKED);
  assign seq_err   = seq_err_reg;
  assign wrap      = wrap_reg;
  assign pos       = pos_of(trk_reg);
  assign expected  = trk_succ;
  assign err_count = err_reg;

endmodule

// File: tb/tb_jk_seq_checker.sv
// Bench for jk_seq_checker: default instance plus a narrow-counter instance
// (ERR_W=2, UNLOCK_CNT=7), driven from vector tables through a scoreboard.
module tb_jk_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] code = 3'b000;
  logic       code_valid = 1'b0;
  logic       clr_err = 1'b0;

  logic       locked_a, seq_err_a, wrap_a;
  logic [2:0] pos_a, expected_a;
  logic [7:0] err_a;
  logic       locked_b, seq_err_b, wrap_b;
  logic [2:0] pos_b, expected_b;
  logic [1:0] err_b;

  jk_seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .clr_err(clr_err), .locked(locked_a), .seq_err(seq_err_a), .wrap(wrap_a),
    .pos(pos_a), .expected(expected_a), .err_count(err_a)
  );

  jk_seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(7), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .clr_err(clr_err), .locked(locked_b), .seq_err(seq_err_b), .wrap(wrap_b),
    .pos(pos_b), .expected(expected_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic       clr;
    logic       l;
    logic       se;
    logic       wr;
    logic [2:0] pos;
    logic [7:0] err;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b1[$];
  vec_t tab_b2[$];
  logic [2:0] seq_lut [7];

  function automatic vec_t mk(logic v, logic [2:0] c, logic clr, logic l,
                              logic se, logic wr, logic [2:0] p, logic [7:0] e);
    vec_t r;
    r.v = v; r.code = c; r.clr = clr; r.l = l; r.se = se; r.wr = wr; r.pos = p; r.err = e;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0d, want %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one sample, queue its expectation, compare once the DUT has registered it.
  task automatic step(input vec_t v, input bit sel, input string tag, input int idx);
    vec_t       e;
    logic       l, se, wr;
    logic [2:0] p, x;
    logic [7:0] er;
    @(negedge clk);
    code_valid = v.v; code = v.code; clr_err = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (sel) begin
      l = locked_b; se = seq_err_b; wr = wrap_b; p = pos_b; x = expected_b; er = {6'd0, err_b};
    end else begin
      l = locked_a; se = seq_err_a; wr = wrap_a; p = pos_a; x = expected_a; er = err_a;
    end
    $display("%s %0d: valid=%0b code=%03b clr=%0b -> locked=%0b seq_err=%0b wrap=%0b pos=%0d expected=%03b err=%0d",
             tag, idx, v.v, v.code, v.clr, l, se, wr, p, x, er);
    chk({tag, " locked"}, idx, {7'd0, l}, {7'd0, e.l});
    chk({tag, " seq_err"}, idx, {7'd0, se}, {7'd0, e.se});
    chk({tag, " wrap"}, idx, {7'd0, wr}, {7'd0, e.wr});
    chk({tag, " pos"}, idx, {5'd0, p}, {5'd0, e.pos});
    chk({tag, " expected"}, idx, {5'd0, x}, {5'd0, seq_lut[(int'(e.pos) + 1) % 7]});
    chk({tag, " err_count"}, idx, er, e.err);
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, " locked"}, 0, {7'd0, locked_b}, 8'd0);
    chk({tag, " seq_err"}, 0, {7'd0, seq_err_b}, 8'd0);
    chk({tag, " wrap"}, 0, {7'd0, wrap_b}, 8'd0);
    chk({tag, " pos"}, 0, {5'd0, pos_b}, 8'd0);
    chk({tag, " expected"}, 0, {5'd0, expected_b}, 8'd1);
    chk({tag, " err_count"}, 0, {6'd0, err_b}, 8'd0);
  endtask

  initial begin
    seq_lut[0] = 3'b000; seq_lut[1] = 3'b001; seq_lut[2] = 3'b010; seq_lut[3] = 3'b100;
    seq_lut[4] = 3'b101; seq_lut[5] = 3'b110; seq_lut[6] = 3'b111;

    // Default instance: illegal seed, clean lock, single error, double error, gaps, clear.
    tab_a.push_back(mk(1, 3'b011, 0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk(1, 3'b001, 0, 0, 0, 0, 1, 0));
    tab_a.push_back(mk(1, 3'b010, 0, 0, 0, 0, 2, 0));
    tab_a.push_back(mk(1, 3'b100, 0, 1, 0, 0, 3, 0));
    tab_a.push_back(mk(1, 3'b101, 0, 1, 0, 0, 4, 0));
    tab_a.push_back(mk(1, 3'b110, 0, 1, 0, 0, 5, 0));
    tab_a.push_back(mk(1, 3'b111, 0, 1, 0, 0, 6, 0));
    tab_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0, 0));
    tab_a.push_back(mk(1, 3'b001, 0, 1, 0, 0, 1, 0));
    tab_a.push_back(mk(1, 3'b010, 0, 1, 0, 0, 2, 0));
    tab_a.push_back(mk(1, 3'b011, 0, 1, 1, 0, 3, 1));
    tab_a.push_back(mk(1, 3'b101, 0, 1, 0, 0, 4, 1));
    tab_a.push_back(mk(1, 3'b110, 0, 1, 0, 0, 5, 1));
    tab_a.push_back(mk(1, 3'b111, 0, 1, 0, 0, 6, 1));
    tab_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0, 1));
    tab_a.push_back(mk(1, 3'b001, 0, 1, 0, 0, 1, 1));
    tab_a.push_back(mk(1, 3'b010, 0, 1, 0, 0, 2, 1));
    tab_a.push_back(mk(1, 3'b111, 0, 1, 1, 0, 3, 2));
    tab_a.push_back(mk(1, 3'b111, 0, 0, 1, 0, 6, 3));
    tab_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 3));
    tab_a.push_back(mk(1, 3'b001, 0, 0, 0, 0, 1, 3));
    tab_a.push_back(mk(1, 3'b010, 0, 1, 0, 0, 2, 3));
    tab_a.push_back(mk(1, 3'b100, 0, 1, 0, 0, 3, 3));
    for (int i = 0; i < 5; i++)
      tab_a.push_back(mk(0, 3'($urandom_range(0, 7)), 0, 1, 0, 0, 3, 3));
    tab_a.push_back(mk(1, 3'b101, 0, 1, 0, 0, 4, 3));
    tab_a.push_back(mk(1, 3'b110, 0, 1, 0, 0, 5, 3));
    tab_a.push_back(mk(0, 3'($urandom_range(0, 7)), 1, 1, 0, 0, 5, 0));
    tab_a.push_back(mk(1, 3'b000, 1, 1, 1, 0, 6, 0));
    tab_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0, 0));

    // Narrow instance: lock, then five isolated errors saturate the 2-bit count.
    tab_b1.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0));
    tab_b1.push_back(mk(1, 3'b001, 0, 0, 0, 0, 1, 0));
    tab_b1.push_back(mk(1, 3'b010, 0, 0, 0, 0, 2, 0));
    tab_b1.push_back(mk(1, 3'b100, 0, 1, 0, 0, 3, 0));
    tab_b1.push_back(mk(1, 3'b011, 0, 1, 1, 0, 4, 1));
    tab_b1.push_back(mk(1, 3'b110, 0, 1, 0, 0, 5, 1));
    tab_b1.push_back(mk(1, 3'b011, 0, 1, 1, 0, 6, 2));
    tab_b1.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0, 2));
    tab_b1.push_back(mk(1, 3'b011, 0, 1, 1, 0, 1, 3));
    tab_b1.push_back(mk(1, 3'b010, 0, 1, 0, 0, 2, 3));
    tab_b1.push_back(mk(1, 3'b011, 0, 1, 1, 0, 3, 3));
    tab_b1.push_back(mk(1, 3'b101, 0, 1, 0, 0, 4, 3));
    tab_b1.push_back(mk(1, 3'b011, 0, 1, 1, 0, 5, 3));
    tab_b1.push_back(mk(1, 3'b111, 0, 1, 0, 0, 6, 3));

    // After async reset: re-seed mid-sequence, no wrap in HUNT, clear beats increment.
    tab_b2.push_back(mk(1, 3'b101, 0, 0, 0, 0, 4, 0));
    tab_b2.push_back(mk(1, 3'b110, 0, 0, 0, 0, 5, 0));
    tab_b2.push_back(mk(1, 3'b111, 0, 0, 0, 0, 6, 0));
    tab_b2.push_back(mk(1, 3'b000, 0, 1, 0, 0, 0, 0));
    tab_b2.push_back(mk(1, 3'b011, 1, 1, 1, 0, 1, 0));
    tab_b2.push_back(mk(1, 3'b010, 0, 1, 0, 0, 2, 0));

    repeat (3) @(negedge clk);
    chk("reset_a locked", 0, {7'd0, locked_a}, 8'd0);
    chk("reset_a expected", 0, {5'd0, expected_a}, 8'd1);
    chk("reset_a err_count", 0, err_a, 8'd0);
    chk_reset_b("reset_b");
    reset = 1'b1;

    for (int i = 0; i < tab_a.size(); i++) step(tab_a[i], 1'b0, "A", i);

    @(negedge clk); reset = 1'b0; code_valid = 1'b0; clr_err = 1'b0;
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < tab_b1.size(); i++) step(tab_b1[i], 1'b1, "B1", i);

    // Reset asserted between edges must clear outputs without waiting for a clock.
    @(negedge clk);
    code_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_b("async_reset_b");
    chk("async_reset_a locked", 0, {7'd0, locked_a}, 8'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < tab_b2.size(); i++) step(tab_b2[i], 1'b1, "B2", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_seq_checker.md
# jk_seq_checker

Receive-side checker for the 3-bit JK-flip-flop sequence counter output. Samples the 3-bit code on each valid cycle, locks onto the fixed 7-state sequence, and flags out-of-sequence codes. Keeps a flywheel position and a saturating error count. Sits on the consumer side of any counter-driven code bus, sampling on the rising clock edge, half a cycle after the counter's falling-edge update.

## Interface
- LOCK_CNT, 3: consecutive correct transitions required to enter LOCKED (1..7)
- UNLOCK_CNT, 2: consecutive mismatches in LOCKED that force HUNT (1..7)
- ERR_W, 8: err_count width
- clk  input  1  sampling clock, rising edge
- reset  input  1  reset, asynchronous, active-low
- code  input  3  observed sequence code
- code_valid  input  1  code sampled only when high
- clr_err  input  1  synchronous clear of err_count
- locked  output  1  checker is in LOCKED
- seq_err  output  1  one-cycle pulse per mismatch while LOCKED
- wrap  output  1  one-cycle pulse on matched 111→000 while LOCKED
- pos  output  3  index of tracked code (0..6)
- expected  output  3  next code the checker expects
- err_count  output  ERR_W  saturating mismatch count

## Operation
- Sequence, fixed: 000→001→010→100→101→110→111→000. pos map: 000=0, 001=1, 010=2, 100=3, 101=4, 110=5, 111=6. Code 011 is illegal and never matches.
- Internal state:
  - trk: tracked code register; pos and expected are decoded from it.
  - trk_ok: trk holds a legal code.
  - good_run and bad_run counters.
  - FSM with states HUNT and LOCKED.
- code_valid low: no state change, seq_err=wrap=0.
- HUNT, valid sample:
  - trk_ok and code==next(trk): good_run+1, trk<=code.
  - Otherwise: good_run<=0. Legal code: trk<=code, trk_ok<=1. Code 011: trk unchanged, trk_ok<=0.
  - good_run reaching LOCK_CNT: go to LOCKED, bad_run<=0.
- LOCKED, valid sample:
  - Match (code==next(trk)): trk<=code, bad_run<=0. wrap=1 if trk was 111.
  - Mismatch: seq_err=1, err_count+1 (saturates at all-ones), bad_run+1.
    - Flywheel: trk<=next(trk), never the bad code.
    - bad_run reaching UNLOCK_CNT: go to HUNT, good_run<=0, trk<=code if legal (trk_ok<=1), else trk_ok<=0.
- seq_err is never asserted in HUNT; errors in HUNT are not counted.
- clr_err: err_count<=0. Wins over a simultaneous increment, so the result is 0.

## Timing
- All outputs are registered and update on the rising edge that takes the sample, visible in the following cycle. Latency is 1 cycle.
- Lock with LOCK_CNT=3 from a clean stream: first sample seeds trk, three matches follow, so locked rises after the 4th valid sample.
- Unlock with UNLOCK_CNT=2: locked falls after the 2nd consecutive mismatching sample. seq_err pulses on both.
- Reset values, applied asynchronously on reset low:
  - locked=0, seq_err=0, wrap=0
  - trk=000, trk_ok=0, so pos=0 and expected=001
  - err_count=0, good_run=0, bad_run=0, FSM in HUNT
- Reset mid-lock clears everything immediately. The first sample after release re-seeds from HUNT.
- Back-to-back valid samples are supported every cycle; gaps of any length are transparent.

## Test plan
- Clean stream: reset, then valid every cycle 000,001,010,100,101,110,111,000 → locked=1 after 4th sample; pos follows 0..6; wrap pulses once after 000 sample; err_count=0.
- Single error: while locked, send 011 in place of 100, then 101 → seq_err for one cycle, err_count=1, locked stays 1, 101 matches with no error.
- Double error: while locked, send 111,111 in place of 100,101 → two seq_err pulses, err_count=2, locked=0 after the 2nd; 4 further clean codes relock.
- Valid gaps: locked, code_valid low for 5 cycles with garbage on code → no seq_err, pos/expected/err_count unchanged; sequence resumes cleanly.
- Counter edges: ERR_W=2, UNLOCK_CNT=7, 5 isolated errors → err_count=3 (saturated); clr_err coincident with an error → err_count=0.
- Async reset: assert reset between clock edges while locked with err_count=3 → all outputs at reset values before the next edge.
